// File: rtl/tournament_predictor.sv
// Tournament branch direction predictor: local two-level + gshare, selected per PC by a chooser.
// Tables are swept to a known state by an init FSM after reset; training is non-speculative.
module tournament_predictor #(
  parameter int PC_WIDTH   = 32,
  parameter int LHT_IDX    = 6,
  parameter int LHIST_BITS = 6,
  parameter int GHR_BITS   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH-1:0] F_PC_i,
  output logic                F_ready_o,
  output logic                F_predict_o,
  output logic                F_local_predict_o,
  output logic                F_global_predict_o,
  input  logic                D_train_valid_i,
  input  logic [PC_WIDTH-1:0] D_train_PC_i,
  input  logic                D_train_predict_i,
  input  logic                D_train_local_predict_i,
  input  logic                D_train_global_predict_i,
  input  logic                D_train_taken_i,
  input  logic                D_train_local_taken_i,
  input  logic                D_train_global_taken_i,
  output logic [31:0]         perf_branches_o,
  output logic [31:0]         perf_mispredicts_o
);

  // state   | meaning
  // ST_INIT | sweeping every table entry to its reset value, predictions forced to 0
  // ST_RUN  | predicting and training
  typedef enum logic {ST_INIT, ST_RUN} state_e;

  localparam int LHT_N   = 1 << LHT_IDX;
  localparam int LPHT_N  = 1 << LHIST_BITS;
  localparam int GPHT_N  = 1 << GHR_BITS;
  localparam int SW_BITS = (LHT_IDX > LHIST_BITS) ?
                           ((LHT_IDX > GHR_BITS) ? LHT_IDX : GHR_BITS) :
                           ((LHIST_BITS > GHR_BITS) ? LHIST_BITS : GHR_BITS);

  state_e                state_q, state_d;
  logic [SW_BITS-1:0]    sweep_q, sweep_d;
  logic [GHR_BITS-1:0]   ghr_q, ghr_d;
  logic [31:0]           perf_br_q, perf_br_d;
  logic [31:0]           perf_mp_q, perf_mp_d;

  logic [LHIST_BITS-1:0] lht_q   [LHT_N];
  logic [1:0]            lpht_q  [LPHT_N];
  logic [1:0]            gpht_q  [GPHT_N];
  logic [1:0]            chsr_q  [GPHT_N];

  logic                  ready;
  logic [LHT_IDX-1:0]    f_li, t_li;
  logic [LHIST_BITS-1:0] f_lp, t_lp;
  logic [GHR_BITS-1:0]   f_ci, f_gi, t_ci, t_gi;
  logic                  t_en, t_o, t_chsr_en;
  logic [1:0]            t_lpht_d, t_gpht_d, t_chsr_d;
  logic [LHIST_BITS-1:0] t_lht_d;
  logic                  sw_lht, sw_lpht, sw_gpht;
  logic                  unused_ok;

  function automatic logic [1:0] sat_upd(input logic [1:0] c, input logic up);
    logic [1:0] r;
    if (up) r = (c == 2'b11) ? c : c + 2'b01;
    else    r = (c == 2'b00) ? c : c - 2'b01;
    return r;
  endfunction

  assign ready = (state_q == ST_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_INIT;
      sweep_q   <= '0;
      ghr_q     <= '0;
      perf_br_q <= '0;
      perf_mp_q <= '0;
    end else begin
      state_q   <= state_d;
      sweep_q   <= sweep_d;
      ghr_q     <= ghr_d;
      perf_br_q <= perf_br_d;
      perf_mp_q <= perf_mp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      ST_INIT: begin
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == {SW_BITS{1'b1}}) state_d = ST_RUN;
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // Fetch-side lookup, purely combinational from the current table contents.
  always_comb begin
    f_li = F_PC_i[LHT_IDX+1:2];
    f_lp = lht_q[f_li];
    f_ci = F_PC_i[GHR_BITS+1:2];
    f_gi = ghr_q ^ f_ci;
    F_ready_o          = ready;
    F_local_predict_o  = ready & lpht_q[f_lp][1];
    F_global_predict_o = ready & gpht_q[f_gi][1];
    F_predict_o        = ready & (chsr_q[f_ci][1] ? gpht_q[f_gi][1] : lpht_q[f_lp][1]);
  end

  // Training uses pre-update history; o reflects the actual direction of the branch.
  always_comb begin
    t_en      = ready & D_train_valid_i & ~rst;
    t_o       = ~(D_train_predict_i ^ D_train_taken_i);
    t_li      = D_train_PC_i[LHT_IDX+1:2];
    t_lp      = lht_q[t_li];
    t_ci      = D_train_PC_i[GHR_BITS+1:2];
    t_gi      = ghr_q ^ t_ci;
    t_lpht_d  = sat_upd(lpht_q[t_lp], t_o);
    t_gpht_d  = sat_upd(gpht_q[t_gi], t_o);
    t_chsr_en = D_train_local_taken_i ^ D_train_global_taken_i;
    t_chsr_d  = sat_upd(chsr_q[t_ci], D_train_global_taken_i);
    t_lht_d   = {lht_q[t_li][LHIST_BITS-2:0], t_o};
    ghr_d     = ghr_q;
    perf_br_d = perf_br_q;
    perf_mp_d = perf_mp_q;
    if (t_en) begin
      ghr_d     = {ghr_q[GHR_BITS-2:0], t_o};
      perf_br_d = perf_br_q + 32'd1;
      if (!D_train_taken_i) perf_mp_d = perf_mp_q + 32'd1;
    end
  end

  always_comb begin
    sw_lht  = ({1'b0, sweep_q} < (SW_BITS+1)'(LHT_N));
    sw_lpht = ({1'b0, sweep_q} < (SW_BITS+1)'(LPHT_N));
    sw_gpht = ({1'b0, sweep_q} < (SW_BITS+1)'(GPHT_N));
  end

  always_ff @(posedge clk) begin
    if (!rst && state_q == ST_INIT) begin
      if (sw_lht)  lht_q[sweep_q[LHT_IDX-1:0]]     <= '0;
      if (sw_lpht) lpht_q[sweep_q[LHIST_BITS-1:0]] <= 2'b01;
      if (sw_gpht) begin
        gpht_q[sweep_q[GHR_BITS-1:0]] <= 2'b01;
        chsr_q[sweep_q[GHR_BITS-1:0]] <= 2'b01;
      end
    end else if (t_en) begin
      lht_q[t_li]  <= t_lht_d;
      lpht_q[t_lp] <= t_lpht_d;
      gpht_q[t_gi] <= t_gpht_d;
      if (t_chsr_en) chsr_q[t_ci] <= t_chsr_d;
    end
  end

  assign perf_branches_o    = perf_br_q;
  assign perf_mispredicts_o = perf_mp_q;

  // Carried predictions and the high/low PC bits are not needed for indexing or training.
  assign unused_ok = ^{F_PC_i[PC_WIDTH-1:GHR_BITS+2], F_PC_i[1:0],
                       D_train_PC_i[PC_WIDTH-1:GHR_BITS+2], D_train_PC_i[1:0],
                       D_train_local_predict_i, D_train_global_predict_i};

endmodule

// File: doc/tournament_predictor.md
Name: tournament_predictor

Overview:
Fetch-side conditional-branch direction predictor. It issues the final, local and global predictions consumed by the decode-stage branch resolver. It is trained by that resolver's per-predictor correctness flags.
- Tournament structure: a local two-level predictor, a gshare global predictor, and a per-PC chooser.
- An init FSM sweeps all tables to a known state after reset.

Parameters:
PC_WIDTH, 32, PC width
LHT_IDX, 6, log2 entries of local history table (index PC[LHT_IDX+1:2])
LHIST_BITS, 6, local history length; local PHT has 2^LHIST_BITS entries
GHR_BITS, 8, global history length; global PHT and chooser have 2^GHR_BITS entries

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
F_PC_i  in  PC_WIDTH  fetch PC to predict
F_ready_o  out  1  1 = tables valid, predictions meaningful
F_predict_o  out  1  final prediction (1 = taken)
F_local_predict_o  out  1  local predictor output
F_global_predict_o  out  1  global predictor output
D_train_valid_i  in  1  resolved conditional branch this cycle
D_train_PC_i  in  PC_WIDTH  PC of the resolved branch
D_train_predict_i  in  1  final prediction carried with the branch
D_train_local_predict_i  in  1  local prediction carried with the branch
D_train_global_predict_i  in  1  global prediction carried with the branch
D_train_taken_i  in  1  1 = final prediction was correct
D_train_local_taken_i  in  1  1 = local prediction was correct
D_train_global_taken_i  in  1  1 = global prediction was correct
perf_branches_o  out  32  count of trained branches
perf_mispredicts_o  out  32  count of trained branches with D_train_taken_i=0

Behaviour:
- Tables:
  - LHT: 2^LHT_IDX x LHIST_BITS.
  - LPHT: 2^LHIST_BITS x 2-bit counters.
  - GPHT: 2^GHR_BITS x 2-bit counters.
  - CHOOSER: 2^GHR_BITS x 2-bit counters.
  - GHR: a GHR_BITS register.
- Indices:
  - li = PC[LHT_IDX+1:2].
  - lp = LHT[li].
  - gi = GHR ^ PC[GHR_BITS+1:2].
  - ci = PC[GHR_BITS+1:2].
- Prediction is combinational from F_PC_i, zero-cycle latency:
  - local = LPHT[lp][1]; global = GPHT[gi][1].
  - final = CHOOSER[ci][1] ? global : local.
  - No same-cycle bypass: a read in the cycle of a write to the same entry returns the pre-write value.
- FSM states INIT and RUN.
  - rst=1 -> INIT, sweep index=0, GHR=0, perf counters=0, F_ready_o=0.
  - INIT: each cycle writes entry sweep_idx of every table whose depth exceeds sweep_idx. LHT gets 0; LPHT, GPHT and CHOOSER get 2'b01.
  - INIT -> RUN after index 2^max(LHT_IDX,LHIST_BITS,GHR_BITS)-1 is written. Defaults: 256 INIT cycles.
  - F_ready_o=1 from the first RUN cycle.
  - rst asserted mid-sweep restarts at index 0.
- While F_ready_o=0: all three prediction outputs are 0, and D_train_valid_i is ignored (no table, GHR or perf update).
- Training (RUN and D_train_valid_i=1) is registered; all updates are visible the next cycle.
  - Outcome o = ~(D_train_predict_i ^ D_train_taken_i).
  - Indices come from D_train_PC_i and current (pre-update) GHR/LHT. History is non-speculative.
  - LPHT[lp], GPHT[gi]: saturating +1 if o, else -1, clamped to 0..3.
  - CHOOSER[ci]: only when local_taken != global_taken. Saturating +1 if global_taken, else -1.
  - LHT[li] <= {LHT[li][LHIST_BITS-2:0], o}; GHR <= {GHR[GHR_BITS-2:0], o}.
  - perf_branches_o +1. perf_mispredicts_o +1 when D_train_taken_i=0. Both wrap mod 2^32.
- Inconsistent correctness flags (local/global outcome disagreeing with o) are not checked; o from the final flags is authoritative.

Test Plan:
1. Pulse rst 1 cycle. Response: F_ready_o=0 for exactly 256 cycles, then 1. All predictions 0 afterwards; perf counters 0.
2. rst at sweep cycle 100. Response: F_ready_o rises 256 cycles after the second rst, not earlier.
3. Train PC=0x80 taken 2 times. Each train sends predict=0, taken=0, local/global flags=0.
   - Expected after: GHR=0b11, perf_mispredicts_o=2.
   - With F_PC_i=0x80 the local path uses the new history (LPHT[3]=01). Global predict follows GPHT[0x03^0x20].
4. Train same PC with local_taken=0, global_taken=1 three times. Response: CHOOSER[0x20] saturates at 3, final = global output. A fourth identical train keeps it at 3.
5. Same cycle: D_train_valid_i for PC 0x40 and F_PC_i=0x40. Response: prediction reflects pre-update tables; updated value seen next cycle.
6. D_train_valid_i=1 during INIT. Response: no change to perf counters, GHR or tables after RUN is entered.
